// File: rtl/inst_cache.sv
// Direct-mapped, read-only instruction cache with multi-word lines.
// Hits answer one cycle after accept; misses refill the whole line word-by-word.
module inst_cache #(
    parameter int INDEX_BITS = 6,
    parameter int OFF_BITS   = 2
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_handle,
    output logic        inst_ready,
    output logic [31:0] inst,
    input  logic        rob_clear,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_data
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int WORDS    = 1 << OFF_BITS;
    localparam int TAG_BITS = 32 - INDEX_BITS - OFF_BITS - 2;

    typedef enum logic {IDLE, REFILL} state_t;

    state_t state_reg, state_next;

    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [31:0]         data_mem [LINES*WORDS];
    logic                valid_reg [LINES];

    logic [TAG_BITS-1:0]   req_tag_reg;
    logic [INDEX_BITS-1:0] req_index_reg;
    logic [OFF_BITS-1:0]   req_off_reg;
    logic [OFF_BITS-1:0]   cnt_reg;
    logic                  pend_reg;
    logic                  ready_q_reg;
    logic [31:0]           inst_reg;

    logic [TAG_BITS-1:0]   a_tag;
    logic [INDEX_BITS-1:0] a_index;
    logic [OFF_BITS-1:0]   a_off;
    logic                  hit;
    logic [31:0]           hit_word;
    logic                  fill_beat;
    logic                  fill_last;
    logic [31:0]           fill_word;
    logic                  unused_addr_bits;

    assign a_tag   = inst_addr[31:INDEX_BITS+OFF_BITS+2];
    assign a_index = inst_addr[INDEX_BITS+OFF_BITS+1:OFF_BITS+2];
    assign a_off   = inst_addr[OFF_BITS+1:2];
    assign unused_addr_bits = ^inst_addr[1:0];

    assign hit      = valid_reg[a_index] && (tag_mem[a_index] == a_tag);
    assign hit_word = data_mem[{a_index, a_off}];

    assign fill_beat = (state_reg == REFILL) && rdy_in && mem_ready;
    assign fill_last = fill_beat && (cnt_reg == OFF_BITS'(WORDS - 1));
    // The requested word may be arriving on this very beat, so bypass the array.
    assign fill_word = (cnt_reg == req_off_reg) ? mem_data
                                                : data_mem[{req_index_reg, req_off_reg}];

    assign mem_addr   = {req_tag_reg, req_index_reg, cnt_reg, 2'b00};
    assign inst       = inst_reg;
    assign inst_ready = ready_q_reg & ~rob_clear;

    always_comb begin
        state_next  = state_reg;
        inst_handle = 1'b0;
        mem_req     = 1'b0;
        case (state_reg)
            IDLE: begin
                inst_handle = inst_req & rdy_in & ~rob_clear;
                if (inst_handle && !hit)
                    state_next = REFILL;
            end
            REFILL: begin
                mem_req = 1'b1;
                if (fill_last)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg     <= IDLE;
            req_tag_reg   <= '0;
            req_index_reg <= '0;
            req_off_reg   <= '0;
            cnt_reg       <= '0;
            pend_reg      <= 1'b0;
            ready_q_reg   <= 1'b0;
            inst_reg      <= '0;
        end else if (rdy_in) begin
            state_reg   <= state_next;
            ready_q_reg <= 1'b0;
            if (inst_handle) begin
                req_tag_reg   <= a_tag;
                req_index_reg <= a_index;
                req_off_reg   <= a_off;
                if (hit) begin
                    inst_reg    <= hit_word;
                    ready_q_reg <= 1'b1;
                end else begin
                    pend_reg <= 1'b1;
                    cnt_reg  <= '0;
                end
            end
            if (fill_beat)
                cnt_reg <= cnt_reg + 1'b1;
            if (fill_last) begin
                pend_reg <= 1'b0;
                if (pend_reg && !rob_clear) begin
                    inst_reg    <= fill_word;
                    ready_q_reg <= 1'b1;
                end
            end
            if (rob_clear)
                pend_reg <= 1'b0;
        end
    end

    // Tag and data arrays carry no reset; valid bits alone decide a hit.
    always_ff @(posedge clk_in) begin
        if (fill_beat) begin
            data_mem[{req_index_reg, cnt_reg}] <= mem_data;
            if (fill_last)
                tag_mem[req_index_reg] <= req_tag_reg;
        end
    end

    // A line is invalidated as its refill starts so a partial line never hits.
    for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
        always_ff @(posedge clk_in or negedge rst_n_in) begin
            if (!rst_n_in) begin
                valid_reg[gi] <= 1'b0;
            end else if (rdy_in) begin
                if (inst_handle && !hit && (a_index == INDEX_BITS'(gi)))
                    valid_reg[gi] <= 1'b0;
                else if (fill_last && (req_index_reg == INDEX_BITS'(gi)))
                    valid_reg[gi] <= 1'b1;
            end
        end
    end

endmodule
